// File: rtl/fir_frame_buffer_pkg.sv
// Shared constants and sample type for the FIR -> frame buffer -> FFT chain.
package fir_frame_buffer_pkg;

  // Sample width; signed Q8.8 two's complement.
  localparam int DATA_W    = 16;
  // Samples per frame; must be a power of two so the index counters wrap naturally.
  localparam int FRAME_LEN = 16;
  // log2(FRAME_LEN).
  localparam int IDX_W     = 4;

  // Q8.8 sample as exchanged between the FIR and FFT stages.
  typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/fir_frame_buffer_frame_bank.sv
// One frame of storage: FRAME_LEN x DATA_W register array with a single
// write port and an asynchronous read port. Contents are never reset.
module fir_frame_buffer_frame_bank
  import fir_frame_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  sample_t          wdata,
  input  logic [IDX_W-1:0] raddr,
  output sample_t          rdata
);

  sample_t mem [FRAME_LEN];

  // Store one sample per enabled write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read so the replayed sample follows the read counter directly.
  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_frame_buffer.sv
// Ping-pong frame buffer: collects FIR samples into two alternating banks and
// replays each completed frame to the FFT with a valid/ready handshake.
module fir_frame_buffer
  import fir_frame_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fir_valid,
  input  logic [DATA_W-1:0] fir_d,
  output logic              frm_valid,
  input  logic              frm_ready,
  output logic [DATA_W-1:0] frm_d,
  output logic [IDX_W-1:0]  frm_idx,
  output logic              frm_last,
  output logic              overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic             wr_bank_reg;
  logic             rd_bank_reg;
  logic [IDX_W-1:0] wr_cnt_reg;
  logic [IDX_W-1:0] rd_cnt_reg;
  logic [1:0]       full_reg;
  logic [1:0]       full_next;
  logic             overflow_reg;

  logic    wr_accept;
  logic    wr_drop;
  logic    wr_done;
  logic    rd_xfer;
  logic    rd_done;
  sample_t bank_rdata [2];

  // Write side decisions use the pre-edge full bit of the target bank, so a
  // bank being released this cycle still rejects an incoming sample.
  assign wr_accept = fir_valid && !full_reg[wr_bank_reg];
  assign wr_drop   = fir_valid &&  full_reg[wr_bank_reg];
  assign wr_done   = wr_accept && (wr_cnt_reg == LAST_IDX);

  // Read side: a bank is presented as soon as it is full.
  assign frm_valid = full_reg[rd_bank_reg];
  assign rd_xfer   = frm_valid && frm_ready;
  assign rd_done   = rd_xfer && (rd_cnt_reg == LAST_IDX);

  // Outputs are forced to zero while nothing is being presented.
  assign frm_d    = frm_valid ? bank_rdata[rd_bank_reg] : '0;
  assign frm_idx  = frm_valid ? rd_cnt_reg : '0;
  assign frm_last = frm_valid && (rd_cnt_reg == LAST_IDX);
  assign overflow = overflow_reg;

  // Per-bank storage and full-bit update. A write can only complete an empty
  // bank and a read can only release a full one, so both never hit one bank.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic bank_we;

      assign bank_we = wr_accept && (wr_bank_reg == 1'(gi));

      assign full_next[gi] =
          (wr_done && (wr_bank_reg == 1'(gi))) ? 1'b1 :
          (rd_done && (rd_bank_reg == 1'(gi))) ? 1'b0 :
          full_reg[gi];

      fir_frame_buffer_frame_bank u_frame_bank (
        .clk   (clk),
        .we    (bank_we),
        .waddr (wr_cnt_reg),
        .wdata (sample_t'(fir_d)),
        .raddr (rd_cnt_reg),
        .rdata (bank_rdata[gi])
      );
    end
  endgenerate

  // Write pointer: advance per accepted sample, switch banks on frame completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_reg  <= '0;
      wr_bank_reg <= 1'b0;
    end else if (wr_accept) begin
      wr_cnt_reg <= wr_cnt_reg + IDX_W'(1);
      if (wr_done) begin
        wr_bank_reg <= ~wr_bank_reg;
      end
    end
  end

  // Read pointer: advance per transfer, switch banks after the last sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_reg  <= '0;
      rd_bank_reg <= 1'b0;
    end else if (rd_xfer) begin
      rd_cnt_reg <= rd_cnt_reg + IDX_W'(1);
      if (rd_done) begin
        rd_bank_reg <= ~rd_bank_reg;
      end
    end
  end

  // Bank occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      full_reg <= full_next;
      if (wr_drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_frame_buffer.sv
// Directed self-checking bench for fir_frame_buffer.
module tb_fir_frame_buffer;

  logic        clk;
  logic        rst;
  logic        fir_valid;
  logic [15:0] fir_d;
  logic        frm_valid;
  logic        frm_ready;
  logic [15:0] frm_d;
  logic [3:0]  frm_idx;
  logic        frm_last;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  fir_frame_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .fir_valid (fir_valid),
    .fir_d     (fir_d),
    .frm_valid (frm_valid),
    .frm_ready (frm_ready),
    .frm_d     (frm_d),
    .frm_idx   (frm_idx),
    .frm_last  (frm_last),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are inspected 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fir_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fir_valid = 1'b1;
    fir_d = 16'h1234;
    frm_ready = 1'b1;
    step();
    step();
    step();
    n_cmp++;
    if ({frm_valid, frm_d, frm_idx, frm_last, overflow} !== 23'd0) begin
      n_err++;
      $display("FAIL reset_hold: valid=%b d=%h idx=%0d last=%b ovf=%b expected all 0",
               frm_valid, frm_d, frm_idx, frm_last, overflow);
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i < 15) begin
        n_cmp++;
        if ({frm_valid, frm_d, frm_idx, frm_last, overflow} !== 23'd0) begin
          n_err++;
          $display("FAIL reset_collect[%0d]: valid=%b d=%h idx=%0d last=%b ovf=%b expected all 0",
                   i, frm_valid, frm_d, frm_idx, frm_last, overflow);
        end
      end else begin
        n_cmp++;
        if (frm_valid !== 1'b1 || frm_d !== 16'h1234 || frm_idx !== 4'd0 || overflow !== 1'b0) begin
          n_err++;
          $display("FAIL reset_first_frame: valid=%b d=%h idx=%0d ovf=%b expected 1 1234 0 0",
                   frm_valid, frm_d, frm_idx, overflow);
        end
      end
    end
    $display("test_reset done");
    do_reset();
  endtask

  task automatic test_basic();
    frm_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      fir_valid = 1'b1;
      fir_d = 16'(i + 1);
      step();
      n_cmp++;
      if (frm_valid !== (i == 15)) begin
        n_err++;
        $display("FAIL basic_latency[%0d]: frm_valid=%b expected %b", i, frm_valid, (i == 15));
      end
    end
    fir_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (frm_valid !== 1'b1 || frm_d !== 16'(k + 1) || frm_idx !== 4'(k) || frm_last !== (k == 15)) begin
        n_err++;
        $display("FAIL basic_out[%0d]: valid=%b d=%h idx=%0d last=%b expected 1 %h %0d %b",
                 k, frm_valid, frm_d, frm_idx, frm_last, 16'(k + 1), k, (k == 15));
      end
      step();
    end
    n_cmp++;
    if (frm_valid !== 1'b0 || frm_d !== 16'h0 || frm_idx !== 4'd0) begin
      n_err++;
      $display("FAIL basic_idle: valid=%b d=%h idx=%0d expected 0 0 0", frm_valid, frm_d, frm_idx);
    end
    $display("test_basic done");
  endtask

  task automatic test_overflow();
    frm_ready = 1'b0;
    for (int i = 0; i < 33; i++) begin
      fir_valid = 1'b1;
      fir_d = 16'h0100 + 16'(i);
      step();
      n_cmp++;
      if (overflow !== (i == 32)) begin
        n_err++;
        $display("FAIL ovf_flag[%0d]: overflow=%b expected %b", i, overflow, (i == 32));
      end
      if (i >= 15) begin
        n_cmp++;
        if (frm_valid !== 1'b1 || frm_d !== 16'h0100 || frm_idx !== 4'd0) begin
          n_err++;
          $display("FAIL ovf_stall[%0d]: valid=%b d=%h idx=%0d expected 1 0100 0",
                   i, frm_valid, frm_d, frm_idx);
        end
      end
    end
    fir_valid = 1'b0;
    frm_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      n_cmp++;
      if (frm_valid !== 1'b1 || frm_d !== 16'h0100 + 16'(k) || frm_idx !== 4'(k % 16) ||
          frm_last !== ((k % 16) == 15) || overflow !== 1'b1) begin
        n_err++;
        $display("FAIL ovf_out[%0d]: valid=%b d=%h idx=%0d last=%b ovf=%b expected 1 %h %0d %b 1",
                 k, frm_valid, frm_d, frm_idx, frm_last, overflow,
                 16'h0100 + 16'(k), k % 16, ((k % 16) == 15));
      end
      step();
    end
    n_cmp++;
    if (frm_valid !== 1'b0 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_after: valid=%b ovf=%b expected 0 1", frm_valid, overflow);
    end
    $display("test_overflow done");
  endtask

  task automatic test_signed();
    logic [15:0] s [16];
    int k;
    int c;
    for (int i = 0; i < 16; i++) s[i] = 16'(i) + 16'h0040;
    s[0] = 16'hFF80;
    s[1] = 16'h8000;
    s[7] = 16'h7FFF;
    s[9] = 16'hFFFF;
    frm_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fir_valid = 1'b1;
      fir_d = s[i];
      step();
    end
    fir_valid = 1'b0;
    k = 0;
    c = 0;
    while (k < 16 && c < 40) begin
      n_cmp++;
      if (frm_valid !== 1'b1 || frm_d !== s[k] || frm_idx !== 4'(k) || frm_last !== (k == 15)) begin
        n_err++;
        $display("FAIL signed[%0d,c%0d]: valid=%b d=%h idx=%0d last=%b expected 1 %h %0d %b",
                 k, c, frm_valid, frm_d, frm_idx, frm_last, s[k], k, (k == 15));
      end
      frm_ready = (c % 2 == 0);
      step();
      if (frm_ready) k++;
      c++;
    end
    n_cmp++;
    if (k != 16 || frm_valid !== 1'b0) begin
      n_err++;
      $display("FAIL signed_done: consumed=%0d valid=%b expected 16 0", k, frm_valid);
    end
    $display("test_signed done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    frm_ready = 1'b1;
    for (int c = 0; c < 96; c++) begin
      if (c >= 16 && c < 80) begin
        n_cmp++;
        if (frm_valid !== 1'b1 || frm_d !== 16'h2000 + 16'(c - 16) ||
            frm_idx !== 4'((c - 16) % 16) || frm_last !== (((c - 16) % 16) == 15)) begin
          n_err++;
          $display("FAIL b2b[%0d]: valid=%b d=%h idx=%0d last=%b expected 1 %h %0d %b",
                   c, frm_valid, frm_d, frm_idx, frm_last, 16'h2000 + 16'(c - 16),
                   (c - 16) % 16, (((c - 16) % 16) == 15));
        end
      end else begin
        n_cmp++;
        if (frm_valid !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_idle[%0d]: valid=%b expected 0", c, frm_valid);
        end
      end
      fir_valid = (c < 64);
      fir_d = 16'h2000 + 16'(c);
      step();
    end
    fir_valid = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_overflow: overflow=%b expected 0", overflow);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_midframe_reset();
    frm_ready = 1'b1;
    for (int c = 0; c < 23; c++) begin
      fir_valid = 1'b1;
      fir_d = 16'h3000 + 16'(c);
      step();
    end
    rst = 1'b1;
    fir_d = 16'h3FFF;
    step();
    rst = 1'b0;
    n_cmp++;
    if (frm_valid !== 1'b0 || frm_d !== 16'h0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_clear: valid=%b d=%h ovf=%b expected 0 0 0", frm_valid, frm_d, overflow);
    end
    for (int i = 0; i < 16; i++) begin
      fir_valid = 1'b1;
      fir_d = 16'h4000 + 16'(i);
      step();
      n_cmp++;
      if (frm_valid !== (i == 15)) begin
        n_err++;
        $display("FAIL midrst_partial[%0d]: frm_valid=%b expected %b", i, frm_valid, (i == 15));
      end
    end
    fir_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (frm_valid !== 1'b1 || frm_d !== 16'h4000 + 16'(k) || frm_idx !== 4'(k) || frm_last !== (k == 15)) begin
        n_err++;
        $display("FAIL midrst_out[%0d]: valid=%b d=%h idx=%0d last=%b expected 1 %h %0d %b",
                 k, frm_valid, frm_d, frm_idx, frm_last, 16'h4000 + 16'(k), k, (k == 15));
      end
      step();
    end
    n_cmp++;
    if (frm_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_end: valid=%b expected 0", frm_valid);
    end
    $display("test_midframe_reset done");
  endtask

  initial begin
    rst = 1'b1;
    fir_valid = 1'b0;
    fir_d = '0;
    frm_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_signed();
    test_back_to_back();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
